// File: rtl/layer0_writeback_if.sv
// rtl/layer0_writeback_if.sv - layer0 result stream in, memory write bus and status out
interface layer0_writeback_if #(
  parameter int DW = 20
);
  logic                 i_valid;
  logic signed [DW-1:0] i_data_0;
  logic signed [DW-1:0] i_data_1;
  logic                 o_go_down;
  logic                 o_cwr;
  logic [11:0]          o_caddr_wr;
  logic signed [DW-1:0] o_cdata_wr;
  logic [2:0]           o_csel;
  logic                 o_done;
  logic                 o_err;

  modport master (
    output i_valid, i_data_0, i_data_1,
    input  o_go_down, o_cwr, o_caddr_wr, o_cdata_wr, o_csel, o_done, o_err
  );

  modport slave (
    input  i_valid, i_data_0, i_data_1,
    output o_go_down, o_cwr, o_caddr_wr, o_cdata_wr, o_csel, o_done, o_err
  );
endinterface

// File: rtl/layer0_writeback.sv
// rtl/layer0_writeback.sv - writes layer-0 results and on-the-fly 2x2 max-pool results to memory
module layer0_writeback #(
  parameter int DW         = 20,
  parameter int FIFO_DEPTH = 128,
  parameter int IMG_W      = 64
) (
  input  logic               clk,
  input  logic               reset,
  layer0_writeback_if.slave  bus
);
  localparam int LW   = $clog2(IMG_W);
  localparam int PCW  = 2 * LW;
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int HALF = IMG_W / 2;
  localparam logic [PCW-1:0] LAST_PC = '1;
  localparam logic [PCW-1:0] PC_ONE  = PCW'(1);
  localparam logic [AW-1:0]  PTR_ONE = AW'(1);
  localparam logic [AW:0]    CNT_ONE = (AW+1)'(1);
  localparam logic [AW:0]    CNT_MAX = (AW+1)'(FIFO_DEPTH);

  typedef struct packed {
    logic                 pool;
    logic [PCW-1:0]       pc;
    logic signed [DW-1:0] d0;
    logic signed [DW-1:0] d1;
    logic signed [DW-1:0] p0;
    logic signed [DW-1:0] p1;
  } entry_t;

  typedef enum logic [2:0] {S_IDLE, S_W0, S_W1, S_P0, S_P1} state_t;

  function automatic logic signed [DW-1:0] smax(input logic signed [DW-1:0] a,
                                                input logic signed [DW-1:0] b);
    return (a > b) ? a : b;
  endfunction

  logic [PCW-1:0]       r_pc;
  logic                 r_in_done;
  logic signed [DW-1:0] r_h0, r_h1;
  logic signed [DW-1:0] r_lb0 [HALF];
  logic signed [DW-1:0] r_lb1 [HALF];
  entry_t               r_mem [FIFO_DEPTH];
  logic [AW-1:0]        r_wptr, r_rptr;
  logic [AW:0]          r_count;
  logic                 r_err, r_done;
  state_t               r_state;
  logic                 r_cwr;
  logic [11:0]          r_caddr;
  logic signed [DW-1:0] r_cdata;
  logic [2:0]           r_csel;

  logic                 w_accept, w_full, w_push, w_pop, w_more, w_use_next;
  logic [LW-1:0]        w_row, w_col;
  logic [LW-2:0]        w_lbi;
  logic signed [DW-1:0] w_p0, w_p1;
  logic [AW-1:0]        w_rptr_nx;
  entry_t               w_new, w_head, w_second, w_ent;
  state_t               w_nstate;
  logic                 w_cwr;
  logic [2:0]           w_csel;
  logic [11:0]          w_caddr, w_pool_addr;
  logic signed [DW-1:0] w_cdata;

  assign w_accept = bus.i_valid & ~r_in_done;
  assign w_row    = r_pc[PCW-1:LW];
  assign w_col    = r_pc[LW-1:0];
  assign w_lbi    = w_col[LW-1:1];
  assign w_full   = (r_count == CNT_MAX);
  assign w_push   = w_accept & ~w_full;
  // Only meaningful on odd row / odd col; the pool flag gates its use downstream.
  assign w_p0     = smax(smax(r_lb0[w_lbi], r_h0), bus.i_data_0);
  assign w_p1     = smax(smax(r_lb1[w_lbi], r_h1), bus.i_data_1);
  assign w_new    = {w_row[0] & w_col[0], r_pc, bus.i_data_0, bus.i_data_1, w_p0, w_p1};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc      <= '0;
      r_in_done <= 1'b0;
      r_h0      <= '0;
      r_h1      <= '0;
      r_err     <= 1'b0;
      for (int i = 0; i < HALF; i++) begin
        r_lb0[i] <= '0;
        r_lb1[i] <= '0;
      end
    end else if (w_accept) begin
      r_pc <= r_pc + PC_ONE;
      if (r_pc == LAST_PC) r_in_done <= 1'b1;
      if (!w_col[0]) begin
        r_h0 <= bus.i_data_0;
        r_h1 <= bus.i_data_1;
      end else if (!w_row[0]) begin
        r_lb0[w_lbi] <= smax(r_h0, bus.i_data_0);
        r_lb1[w_lbi] <= smax(r_h1, bus.i_data_1);
      end
      if (w_full) r_err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= w_new;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_ONE;
      if (w_pop)  r_rptr <= r_rptr + PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Lookahead to the second entry lets the next W0 follow the final write with no gap.
  assign w_rptr_nx = r_rptr + PTR_ONE;
  assign w_head    = r_mem[r_rptr];
  assign w_second  = r_mem[w_rptr_nx];
  assign w_more    = (r_count > CNT_ONE);

  always_comb begin
    w_nstate   = r_state;
    w_pop      = 1'b0;
    w_use_next = 1'b0;
    case (r_state)
      S_IDLE: if (r_count != '0) w_nstate = S_W0;
      S_W0:   w_nstate = S_W1;
      S_W1: begin
        if (w_head.pool) begin
          w_nstate = S_P0;
        end else begin
          w_pop      = 1'b1;
          w_use_next = w_more;
          w_nstate   = w_more ? S_W0 : S_IDLE;
        end
      end
      S_P0:   w_nstate = S_P1;
      S_P1: begin
        w_pop      = 1'b1;
        w_use_next = w_more;
        w_nstate   = w_more ? S_W0 : S_IDLE;
      end
      default: w_nstate = S_IDLE;
    endcase
  end

  always_comb begin
    w_ent       = w_use_next ? w_second : w_head;
    w_pool_addr = 12'({w_ent.pc[PCW-1:LW+1], w_ent.pc[LW-1:1]});
    w_cwr       = 1'b0;
    w_csel      = 3'b000;
    w_caddr     = '0;
    w_cdata     = '0;
    case (w_nstate)
      S_W0: begin w_cwr = 1'b1; w_csel = 3'b001; w_caddr = 12'(w_ent.pc); w_cdata = w_ent.d0; end
      S_W1: begin w_cwr = 1'b1; w_csel = 3'b010; w_caddr = 12'(w_ent.pc); w_cdata = w_ent.d1; end
      S_P0: begin w_cwr = 1'b1; w_csel = 3'b011; w_caddr = w_pool_addr;  w_cdata = w_ent.p0; end
      S_P1: begin w_cwr = 1'b1; w_csel = 3'b100; w_caddr = w_pool_addr;  w_cdata = w_ent.p1; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cwr   <= 1'b0;
      r_csel  <= 3'b000;
      r_caddr <= '0;
      r_cdata <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_nstate;
      r_cwr   <= w_cwr;
      r_csel  <= w_csel;
      r_caddr <= w_caddr;
      r_cdata <= w_cdata;
      if (r_state == S_P1 && w_head.pc == LAST_PC) r_done <= 1'b1;
    end
  end

  assign bus.o_go_down  = (r_count == '0) && (r_state == S_IDLE) && (r_pc[LW:0] == '0) && !r_done;
  assign bus.o_cwr      = r_cwr;
  assign bus.o_csel     = r_csel;
  assign bus.o_caddr_wr = r_caddr;
  assign bus.o_cdata_wr = r_cdata;
  assign bus.o_done     = r_done;
  assign bus.o_err      = r_err;
endmodule
